// File: rtl/id_forward_ctrl.sv
// ID-stage forwarding and load-use hazard controller. A shadow pipeline of
// EX/MEM/WB destination info drives the operand-select codes, stall and IF/ID flush.
module id_forward_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic [4:0]  id_dst,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        Branch_or_Jump,
  output logic [1:0]  red1_select_signal,
  output logic [1:0]  red2_select_signal,
  output logic        stall,
  output logic        flush_if_id,
  output logic [15:0] stall_count
);

  typedef struct packed {
    logic       valid;
    logic [4:0] dst;
    logic       reg_write;
    logic       mem_read;
  } shadow_t;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [1:0] SEL_WB  = 2'b11;

  shadow_t ex_q, mem_q, wb_q;
  shadow_t ex_next;

  logic rs_ex_hit, rs_mem_hit, rs_wb_hit;
  logic rt_ex_hit, rt_mem_hit, rt_wb_hit;

  function automatic logic hit(input shadow_t s, input logic [4:0] r);
    return s.valid && s.reg_write && (s.dst == r) && (r != 5'd0);
  endfunction

  // A load in EX never forwards; its data first appears at the MEM output,
  // so an EX load hit falls through to the MEM/WB terms.
  function automatic logic [1:0] pick_sel(input logic use_src, input logic ex_hit,
                                          input logic ex_load, input logic mem_hit,
                                          input logic wb_hit);
    logic [1:0] sel;
    sel = SEL_RF;
    if (!use_src)               sel = SEL_RF;
    else if (ex_hit && !ex_load) sel = SEL_EX;
    else if (mem_hit)           sel = SEL_MEM;
    else if (wb_hit)            sel = SEL_WB;
    return sel;
  endfunction

  always_comb begin
    rs_ex_hit  = hit(ex_q,  id_rs);
    rs_mem_hit = hit(mem_q, id_rs);
    rs_wb_hit  = hit(wb_q,  id_rs);
    rt_ex_hit  = hit(ex_q,  id_rt);
    rt_mem_hit = hit(mem_q, id_rt);
    rt_wb_hit  = hit(wb_q,  id_rt);

    stall = id_valid && ex_q.mem_read &&
            ((id_uses_rs && rs_ex_hit) || (id_uses_rt && rt_ex_hit));

    red1_select_signal = pick_sel(id_valid && id_uses_rs, rs_ex_hit, ex_q.mem_read,
                                  rs_mem_hit, rs_wb_hit);
    red2_select_signal = pick_sel(id_valid && id_uses_rt, rt_ex_hit, ex_q.mem_read,
                                  rt_mem_hit, rt_wb_hit);

    // The branch compare is meaningless while its operand is still in flight.
    flush_if_id = Branch_or_Jump && !stall && id_valid;

    ex_next = '0;
    if (id_valid && !stall) begin
      ex_next.valid     = 1'b1;
      ex_next.dst       = id_dst;
      ex_next.reg_write = id_reg_write;
      ex_next.mem_read  = id_mem_read;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_count <= 16'd0;
    end else if (!hold) begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= ex_next;
      if (stall && (stall_count != 16'hFFFF))
        stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_id_forward_ctrl.sv
// Directed bench for id_forward_ctrl: each task plays a short instruction
// sequence through ID and checks selects, stall, flush and stall count.
module tb_id_forward_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        hold;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic [4:0]  id_dst;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        Branch_or_Jump;
  logic [1:0]  red1_select_signal;
  logic [1:0]  red2_select_signal;
  logic        stall;
  logic        flush_if_id;
  logic [15:0] stall_count;

  int checks = 0;
  int errors = 0;

  id_forward_ctrl dut (
    .clk(clk), .rst(rst), .hold(hold), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_dst(id_dst), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .Branch_or_Jump(Branch_or_Jump),
    .red1_select_signal(red1_select_signal), .red2_select_signal(red2_select_signal),
    .stall(stall), .flush_if_id(flush_if_id), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; checks happen 3 units later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic [4:0] dst,
                       input logic rw, input logic mr, input logic bj);
    id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_dst = dst; id_reg_write = rw; id_mem_read = mr; Branch_or_Jump = bj;
  endtask

  task automatic idle(input int n);
    hold = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      hold = 1'($urandom_range(0, 1));
      drive(1'b1, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'b1, 1'b1,
            5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tick();
    end
    settle();
    checks++;
    if (red1_select_signal !== 2'b00) begin
      errors++; $display("FAIL reset_sel1: got %b expected 00", red1_select_signal);
    end
    checks++;
    if (red2_select_signal !== 2'b00) begin
      errors++; $display("FAIL reset_sel2: got %b expected 00", red2_select_signal);
    end
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL reset_stall: got %b expected 0", stall);
    end
    checks++;
    if (stall_count !== 16'd0) begin
      errors++; $display("FAIL reset_count: got %0d expected 0", stall_count);
    end
    rst = 1'b0;
    idle(1);
    settle();
    checks++;
    if (flush_if_id !== 1'b0) begin
      errors++; $display("FAIL reset_flush: got %b expected 0", flush_if_id);
    end
  endtask

  task automatic test_distance_sweep();
    logic [1:0] exp_sel1 [4];
    exp_sel1[0] = 2'b01; exp_sel1[1] = 2'b10; exp_sel1[2] = 2'b11; exp_sel1[3] = 2'b00;
    for (int n = 0; n < 4; n++) begin
      idle(4);
      drive(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0); // add $3
      tick();
      for (int k = 0; k < n; k++) begin
        drive(1'b1, 5'd11, 5'd12, 1'b0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0);
        tick();
      end
      drive(1'b1, 5'd3, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0); // beq $3,$0
      settle();
      checks++;
      if (red1_select_signal !== exp_sel1[n]) begin
        errors++;
        $display("FAIL dist%0d_sel1: got %b expected %b", n, red1_select_signal, exp_sel1[n]);
      end
      checks++;
      if (red2_select_signal !== 2'b00) begin
        errors++; $display("FAIL dist%0d_sel2: got %b expected 00", n, red2_select_signal);
      end
      checks++;
      if (stall !== 1'b0) begin
        errors++; $display("FAIL dist%0d_stall: got %b expected 0", n, stall);
      end
      tick();
    end
  endtask

  task automatic test_load_use();
    idle(4);
    drive(1'b1, 5'd1, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0); // lw $5
    tick();
    drive(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0); // beq $5,$5
    settle();
    checks++;
    if (stall !== 1'b1) begin
      errors++; $display("FAIL lu_stall_first: got %b expected 1", stall);
    end
    tick();
    settle();
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL lu_stall_second: got %b expected 0", stall);
    end
    checks++;
    if (red1_select_signal !== 2'b10) begin
      errors++; $display("FAIL lu_sel1: got %b expected 10", red1_select_signal);
    end
    checks++;
    if (red2_select_signal !== 2'b10) begin
      errors++; $display("FAIL lu_sel2: got %b expected 10", red2_select_signal);
    end
    checks++;
    if (stall_count !== 16'd1) begin
      errors++; $display("FAIL lu_count: got %0d expected 1", stall_count);
    end
    tick();
  endtask

  task automatic test_priority_zero();
    idle(4);
    drive(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0); // add $7
    tick();
    drive(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0); // add $7
    tick();
    drive(1'b1, 5'd7, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); // beq $7
    settle();
    checks++;
    if (red1_select_signal !== 2'b01) begin
      errors++; $display("FAIL prio_sel1: got %b expected 01", red1_select_signal);
    end
    idle(4);
    drive(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0); // writer of $0
    tick();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    settle();
    checks++;
    if (red1_select_signal !== 2'b00) begin
      errors++; $display("FAIL zero_sel1: got %b expected 00", red1_select_signal);
    end
    checks++;
    if (red2_select_signal !== 2'b00) begin
      errors++; $display("FAIL zero_sel2: got %b expected 00", red2_select_signal);
    end
    tick();
  endtask

  task automatic test_flush();
    logic [15:0] c0;
    idle(4);
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    settle();
    checks++;
    if (flush_if_id !== 1'b1) begin
      errors++; $display("FAIL flush_taken: got %b expected 1", flush_if_id);
    end
    tick();
    drive(1'b0, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    settle();
    checks++;
    if (flush_if_id !== 1'b0) begin
      errors++; $display("FAIL flush_invalid: got %b expected 0", flush_if_id);
    end
    idle(4);
    c0 = stall_count;
    drive(1'b1, 5'd1, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0); // lw $4
    tick();
    drive(1'b1, 5'd0, 5'd4, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1); // beq on rt=$4, taken
    settle();
    checks++;
    if (stall !== 1'b1) begin
      errors++; $display("FAIL flush_stall: got %b expected 1", stall);
    end
    checks++;
    if (flush_if_id !== 1'b0) begin
      errors++; $display("FAIL flush_during_stall: got %b expected 0", flush_if_id);
    end
    tick();
    settle();
    checks++;
    if (flush_if_id !== 1'b1) begin
      errors++; $display("FAIL flush_after_stall: got %b expected 1", flush_if_id);
    end
    checks++;
    if (stall_count !== c0 + 16'd1) begin
      errors++; $display("FAIL flush_count: got %0d expected %0d", stall_count, c0 + 16'd1);
    end
    tick();
  endtask

  task automatic test_hold();
    logic [15:0] c0;
    idle(4);
    c0 = stall_count;
    drive(1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0); // add $9
    tick();
    drive(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); // beq $9
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++;
      if (red1_select_signal !== 2'b01) begin
        errors++; $display("FAIL hold_sel1_c%0d: got %b expected 01", i, red1_select_signal);
      end
      tick();
    end
    hold = 1'b0;
    settle();
    checks++;
    if (red1_select_signal !== 2'b01) begin
      errors++; $display("FAIL hold_release_sel1: got %b expected 01", red1_select_signal);
    end
    tick();
    drive(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    settle();
    checks++;
    if (red1_select_signal !== 2'b10) begin
      errors++; $display("FAIL hold_advance_sel1: got %b expected 10", red1_select_signal);
    end
    checks++;
    if (stall_count !== c0) begin
      errors++; $display("FAIL hold_count: got %0d expected %0d", stall_count, c0);
    end
    // A load-use stall held for two edges counts only on the releasing edge.
    idle(4);
    drive(1'b1, 5'd1, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0); // lw $6
    tick();
    drive(1'b1, 5'd6, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    hold = 1'b1;
    tick();
    tick();
    settle();
    checks++;
    if (stall !== 1'b1) begin
      errors++; $display("FAIL hold_stall: got %b expected 1", stall);
    end
    checks++;
    if (stall_count !== c0) begin
      errors++; $display("FAIL hold_stall_count: got %0d expected %0d", stall_count, c0);
    end
    hold = 1'b0;
    tick();
    settle();
    checks++;
    if (stall_count !== c0 + 16'd1) begin
      errors++; $display("FAIL hold_release_count: got %0d expected %0d", stall_count, c0 + 16'd1);
    end
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL hold_release_stall: got %b expected 0", stall);
    end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    idle(4);
    drive(1'b1, 5'd1, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0); // lw $8
    tick();
    drive(1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    settle();
    checks++;
    if (stall !== 1'b1) begin
      errors++; $display("FAIL mid_stall_before: got %b expected 1", stall);
    end
    rst = 1'b1;
    hold = 1'b1;
    tick();
    rst = 1'b0;
    hold = 1'b0;
    settle();
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL mid_stall_after: got %b expected 0", stall);
    end
    checks++;
    if (stall_count !== 16'd0) begin
      errors++; $display("FAIL mid_stall_count: got %0d expected 0", stall_count);
    end
    checks++;
    if (red1_select_signal !== 2'b00) begin
      errors++; $display("FAIL mid_stall_sel1: got %b expected 00", red1_select_signal);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1;
    hold = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1;
    test_reset();
    test_distance_sweep();
    test_load_use();
    test_priority_zero();
    test_flush();
    test_hold();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
